input_sequencer: RTL

//  Front-end controller for the board input path of the multi-cycle CPU. Synchronises and debounces
//  the "input number" and "show result" buttons, and samples the 4-bit switch value on each clean

---
 rtl/io_pkg.sv | 15 +
 rtl/button_debouncer.sv | 90 +++++++++
 rtl/input_sequencer.sv | 97 +++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared encodings and default sizes for the board input front end.
package io_pkg;

  typedef enum logic [1:0] {
    DB_WAIT_RELEASE = 2'd0,
    DB_IDLE         = 2'd1,
    DB_ARMING       = 2'd2,
    DB_PRESSED      = 2'd3
  } db_state_e;

  localparam int DEF_DATA_W          = 4;
  localparam int DEF_DEPTH           = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus press debouncer; emits a registered one-cycle pulse per clean press.
//   state        | meaning
//   WAIT_RELEASE | button must read 0 for CYCLES samples before a new press is accepted
//   IDLE         | released and stable, waiting for a rising level
//   ARMING       | counting consecutive high samples
//   PRESSED      | press accepted, pulse issued this cycle
module button_debouncer
  import io_pkg::*;
#(
  parameter int CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES);
  localparam logic [CW-1:0] CNT_REL = CW'(CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          sync1_q, sync2_q;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= DB_WAIT_RELEASE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    case (state_q)
      DB_WAIT_RELEASE: begin
        if (sync2_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_REL) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DB_IDLE: begin
        if (sync2_q) begin
          state_d = DB_ARMING;
          cnt_d   = CNT_ONE;
        end
      end
      DB_ARMING: begin
        if (!sync2_q) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = DB_PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DB_PRESSED: begin
        state_d = DB_WAIT_RELEASE;
        cnt_d   = '0;
      end
      default: begin
        state_d = DB_WAIT_RELEASE;
        cnt_d   = '0;
      end
    endcase
  end

  assign press_o = press_q;

endmodule

// File: rtl/input_sequencer.sv
// Board input front end: debounced buttons, switch sampling into a small FIFO, show-result flag.
module input_sequencer
  import io_pkg::*;
#(
  parameter int DATA_W          = DEF_DATA_W,
  parameter int DEPTH           = DEF_DEPTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_W-1:0]         input_signal,
  input  logic                      input_number_select,
  input  logic                      output_number_select,
  output logic                      in_valid,
  output logic [DATA_W-1:0]         in_data,
  input  logic                      in_ready,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      overflow,
  input  logic                      ovf_clr,
  output logic                      show_computation_result,
  input  logic                      show_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic              in_press, out_press;
  logic [DATA_W-1:0] sig_sync1_q, sig_sync2_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, show_q;
  logic              full, pop, do_push, drop;

  button_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_in_db (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .btn_i   (input_number_select),
    .press_o (in_press)
  );

  button_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_out_db (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .btn_i   (output_number_select),
    .press_o (out_press)
  );

  // A pop frees the slot in the same cycle, so a push into a full FIFO is legal alongside it.
  assign full    = (count_q == FULL_CNT);
  assign pop     = in_valid && in_ready;
  assign do_push = in_press && (!full || pop);
  assign drop    = in_press && full && !pop;

  always_comb begin
    count_d = count_q;
    case ({do_push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_sync1_q <= '0;
      sig_sync2_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      show_q      <= 1'b0;
    end else begin
      sig_sync1_q <= input_signal;
      sig_sync2_q <= sig_sync1_q;
      count_q     <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop)         overflow_q <= 1'b1;
      else if (ovf_clr) overflow_q <= 1'b0;
      if (out_press)     show_q <= 1'b1;
      else if (show_clr) show_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= sig_sync2_q;
  end

  assign in_valid                = (count_q != '0);
  assign in_data                 = in_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count              = count_q;
  assign overflow                = overflow_q;
  assign show_computation_result = show_q;

endmodule
